// File: rtl/download_packer.sv
`default_nettype none
// ============================================================================
// Module   : download_packer
// Purpose  : Packs loader byte strobes into 32-bit words, buffers them in a
//            small FIFO and writes them to SDRAM over a req/ack/valid handshake.
//            Define DOWNLOAD_CHECKSUM_EN to add a running sum of written words.
// Revision : 1.0 - initial release
// ============================================================================
module download_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] ROM_INDEX  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic [15:0] ioctl_index,
    input  logic        ioctl_wr,
    input  logic        ioctl_download,
    output logic        ioctl_wait,
    output logic [22:0] sdram_addr,
    output logic [31:0] sdram_data,
    output logic        sdram_we,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_valid,
`ifdef DOWNLOAD_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    output logic        done,
    output logic        overrun
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full       = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_wait_level = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]      r_word;
    logic [3:0]       r_lane_valid;
    logic [22:0]      r_word_addr;
    logic             r_full_pending;
    logic             r_dl_prev;
    logic             r_seen;
    logic             r_done;
    logic             r_overrun;

    logic [22:0]      r_mem_addr [FIFO_DEPTH];
    logic [31:0]      r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic [1:0]       w_lane;
    logic             w_fall;
    logic             w_push;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop;
    logic             w_quiet;
    logic [31:0]      w_word_next;
    logic [3:0]       w_valid_next;

    assign w_accept = ioctl_download && ioctl_wr && (ioctl_index == ROM_INDEX);
    assign w_lane   = ioctl_addr[1:0];
    assign w_fall   = r_dl_prev && !ioctl_download;
    assign w_full   = (r_count == c_full);

    // A word leaves the packer one cycle after its top lane lands, when the
    // loader jumps to another word, or when the download ends part-way.
    assign w_push = r_full_pending
                 || (w_fall && (r_lane_valid != 4'b0000))
                 || (w_accept && (r_lane_valid != 4'b0000)
                              && (ioctl_addr[24:2] != r_word_addr));
    assign w_push_ok = w_push && !w_full;

    always_comb begin
        w_word_next  = w_push ? 32'h0 : r_word;
        w_valid_next = w_push ? 4'b0000 : r_lane_valid;
        if (w_accept) begin
            case (w_lane)
                2'd0:    w_word_next[7:0]   = ioctl_data;
                2'd1:    w_word_next[15:8]  = ioctl_data;
                2'd2:    w_word_next[23:16] = ioctl_data;
                default: w_word_next[31:24] = ioctl_data;
            endcase
            w_valid_next[w_lane] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word         <= 32'h0;
            r_lane_valid   <= 4'b0000;
            r_word_addr    <= 23'h0;
            r_full_pending <= 1'b0;
            r_dl_prev      <= 1'b0;
        end else begin
            r_word         <= w_word_next;
            r_lane_valid   <= w_valid_next;
            r_full_pending <= w_accept && (w_lane == 2'd3);
            r_dl_prev      <= ioctl_download;
            if (w_accept) begin
                r_word_addr <= ioctl_addr[24:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_addr[r_wr_ptr] <= r_word_addr;
            r_mem_data[r_wr_ptr] <= r_word;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving IDLE on the push itself gives a one-cycle request latency.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_count != '0) || w_push_ok) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sdram_valid) begin
                    w_state_next = ST_IDLE;
                    w_pop        = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_quiet = !ioctl_download && (r_count == '0) && (r_lane_valid == 4'b0000)
                  && !r_full_pending && (r_state == ST_IDLE) && !w_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= r_seen && w_quiet;
            if (r_seen && w_quiet) begin
                r_seen <= 1'b0;
            end else if (w_accept) begin
                r_seen <= 1'b1;
            end
        end
    end

`ifdef DOWNLOAD_CHECKSUM_EN
    logic        w_rise;
    logic [31:0] r_checksum;

    assign w_rise = !r_dl_prev && ioctl_download;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= 32'h0;
        end else if (w_rise) begin
            r_checksum <= 32'h0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + r_mem_data[r_rd_ptr];
        end
    end

    assign checksum = r_checksum;
`endif

    assign sdram_req  = (r_state == ST_REQ);
    assign sdram_we   = (r_state == ST_REQ);
    assign sdram_addr = (r_state == ST_REQ) ? r_mem_addr[r_rd_ptr] : 23'h0;
    assign sdram_data = (r_state == ST_REQ) ? r_mem_data[r_rd_ptr] : 32'h0;
    assign ioctl_wait = (r_count >= c_wait_level);
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_download_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_download_packer
// Purpose  : Scoreboard bench for download_packer: byte-level reference model
//            feeds an expected-write queue checked by a request monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_download_packer;

    localparam int unsigned DEPTH   = 4;
    localparam logic [15:0] ROM_IDX = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [15:0] ioctl_index;
    logic        ioctl_wr;
    logic        ioctl_download;
    logic        ioctl_wait;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_we;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_valid;
    logic        done;
    logic        overrun;
`ifdef DOWNLOAD_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    download_packer #(
        .FIFO_DEPTH (DEPTH),
        .ROM_INDEX  (ROM_IDX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_download (ioctl_download),
        .ioctl_wait     (ioctl_wait),
        .sdram_addr     (sdram_addr),
        .sdram_data     (sdram_data),
        .sdram_we       (sdram_we),
        .sdram_req      (sdram_req),
        .sdram_ack      (sdram_ack),
        .sdram_valid    (sdram_valid),
`ifdef DOWNLOAD_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [22:0] addr;
        logic [31:0] data;
    } wr_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t sb_q[$];

    // Reference model: a word is whatever bytes share one word address,
    // closed by its top lane, by a jump elsewhere, or by end of download.
    logic [22:0] m_addr;
    logic [31:0] m_word;
    logic [3:0]  m_mask;
    logic [31:0] m_sum;
    bit          m_dl;
    bit          m_any;
    bit          m_cap_limit;
    int          m_occ;

    int          req_cnt  = 0;
    int          done_cnt = 0;
    bit          resp_en  = 1'b0;
    int          resp_lat = 0;
    logic        prev_req = 1'b0;
    logic [22:0] prev_addr;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_word = 32'h0;
        m_mask = 4'b0000;
        m_addr = 23'h0;
    endtask

    task automatic close_word();
        if (m_cap_limit && m_occ >= int'(DEPTH)) begin
            // dropped by the full buffer
        end else begin
            sb_q.push_back('{addr: m_addr, data: m_word});
            m_occ++;
            m_sum = m_sum + m_word;
        end
        m_word = 32'h0;
        m_mask = 4'b0000;
    endtask

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d, input logic [15:0] idx);
        int lane;
        if (!m_dl || idx != ROM_IDX) return;
        lane = int'(a[1:0]);
        if (m_mask != 4'b0000 && a[24:2] != m_addr) close_word();
        m_word[8*lane +: 8] = d;
        m_mask[lane] = 1'b1;
        m_addr = a[24:2];
        m_any  = 1'b1;
        if (lane == 3) close_word();
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                             input logic [15:0] idx, input bit obey);
        int guard = 0;
        while (obey && ioctl_wait && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL loader wait timeout: ioctl_wait stuck at %0b, required 0", ioctl_wait);
        end
        ioctl_addr  = a;
        ioctl_data  = d;
        ioctl_index = idx;
        ioctl_wr    = 1'b1;
        model_byte(a, d, idx);
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        m_dl  = 1'b1;
        m_any = 1'b0;
        m_sum = 32'h0;
        m_occ = 0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic end_download(input bit obey);
        int guard = 0;
        while (obey && ioctl_wait && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        ioctl_download = 1'b0;
        m_dl = 1'b0;
        if (m_mask != 4'b0000) close_word();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sb_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s drain: %0d writes still outstanding, required 0", name, sb_q.size());
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        m_dl           = 1'b0;
        sb_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Request monitor: every new request must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (sdram_req && !prev_req) begin
                req_cnt++;
                check("request we", sdram_we, 1);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected request: addr %0h data %0h, no write expected",
                             sdram_addr, sdram_data);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("request addr", sdram_addr, e.addr);
                    check("request data", sdram_data, e.data);
                end
            end else if (sdram_req && prev_req) begin
                check("request held stable", {sdram_addr, sdram_data}, {prev_addr, prev_data});
            end
            prev_req  = sdram_req;
            prev_addr = sdram_addr;
            prev_data = sdram_data;
        end
    end

    // SDRAM responder: ack then valid after random short latencies.
    initial begin
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && sdram_req) begin
                repeat ($urandom_range(0, resp_lat)) @(negedge clk);
                sdram_ack = 1'b1;
                @(negedge clk);
                sdram_ack = 1'b0;
                repeat ($urandom_range(0, resp_lat)) @(negedge clk);
                sdram_valid = 1'b1;
                @(negedge clk);
                sdram_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, st;
        bit saw_wait;
        logic [24:0] a;
        logic [15:0] idx;

        reset = 1'b1; ioctl_addr = '0; ioctl_data = '0; ioctl_index = '0;
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        m_cap_limit = 1'b0;
        do_reset();

        check("reset sdram_req", sdram_req, 0);
        check("reset sdram_we", sdram_we, 0);
        check("reset sdram_addr", sdram_addr, 0);
        check("reset sdram_data", sdram_data, 0);
        check("reset ioctl_wait", ioctl_wait, 0);
        check("reset done", done, 0);
        check("reset overrun", overrun, 0);
`ifdef DOWNLOAD_CHECKSUM_EN
        check("reset checksum", checksum, 0);
`endif

        // Full word at address 0, one-cycle ack/valid
        resp_en = 1'b1; resp_lat = 0;
        r0 = req_cnt; d0 = done_cnt;
        start_download();
        send_byte(25'd0, 8'h11, ROM_IDX, 1);
        send_byte(25'd1, 8'h22, ROM_IDX, 1);
        send_byte(25'd2, 8'h33, ROM_IDX, 1);
        send_byte(25'd3, 8'h44, ROM_IDX, 1);
        check("req before push", sdram_req, 0);
        @(negedge clk);
        check("req latency", sdram_req, 1);
        end_download(1);
        drain("full word");
        check("full word request count", req_cnt - r0, 1);
        check("full word done pulses", done_cnt - d0, 1);

        // Partial word flushed on download end
        r0 = req_cnt; d0 = done_cnt;
        start_download();
        send_byte(25'd8, 8'h11, ROM_IDX, 1);
        send_byte(25'd9, 8'h22, ROM_IDX, 1);
        end_download(1);
        drain("partial");
        check("partial request count", req_cnt - r0, 1);
        check("partial done pulses", done_cnt - d0, 1);

        // Foreign index is ignored
        r0 = req_cnt; d0 = done_cnt;
        start_download();
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i + 5), 16'h0001, 1);
        end_download(1);
        repeat (20) @(negedge clk);
        check("foreign index requests", req_cnt - r0, 0);
        check("foreign index done pulses", done_cnt - d0, 0);

        // Back-pressure: loader honours ioctl_wait while SDRAM is stalled
        do_reset();
        resp_en = 1'b0;
        r0 = req_cnt; d0 = done_cnt; saw_wait = 1'b0;
        start_download();
        for (int i = 0; i < 64; i++) begin
            if (!resp_en && ioctl_wait) begin
                saw_wait = 1'b1;
                check("wait occupancy", m_occ, DEPTH - 1);
                check("stall overrun", overrun, 0);
                repeat (10) @(negedge clk);
                check("loader stalled wait", ioctl_wait, 1);
                resp_en = 1'b1; resp_lat = 1;
            end
            send_byte(25'(i), 8'($urandom), ROM_IDX, 1);
        end
        check("wait observed", saw_wait, 1);
        end_download(1);
        drain("backpressure");
        check("backpressure overrun", overrun, 0);
        check("backpressure requests", req_cnt - r0, 16);
        check("backpressure done", done_cnt - d0, 1);
        check("wait released", ioctl_wait, 0);

        // Loader ignores ioctl_wait: words beyond capacity are lost
        do_reset();
        resp_en = 1'b0; m_cap_limit = 1'b1;
        r0 = req_cnt; d0 = done_cnt;
        start_download();
        for (int i = 0; i < 64; i++) send_byte(25'(i), 8'($urandom), ROM_IDX, 0);
        check("overflow overrun", overrun, 1);
        end_download(0);
        resp_en = 1'b1; resp_lat = 0;
        drain("overflow");
        m_cap_limit = 1'b0;
        check("overflow requests", req_cnt - r0, 4);
        check("overrun sticky", overrun, 1);
        check("overflow done", done_cnt - d0, 1);

        // Reset while a request is outstanding
        do_reset();
        resp_en = 1'b0;
        start_download();
        for (int i = 0; i < 4; i++) send_byte(25'(16'h100 + i), 8'(i + 1), ROM_IDX, 1);
        st = 0;
        while (!sdram_req && st < 10) begin
            @(negedge clk);
            st++;
        end
        check("reached REQ", sdram_req, 1);
        reset = 1'b1; ioctl_download = 1'b0; m_dl = 1'b0;
        @(negedge clk);
        check("req after reset", sdram_req, 0);
        check("wait after reset", ioctl_wait, 0);
        reset = 1'b0;
        sb_q.delete(); model_clear();
        r0 = req_cnt; d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("no request after reset", req_cnt - r0, 0);
        check("no done after reset", done_cnt - d0, 0);

`ifdef DOWNLOAD_CHECKSUM_EN
        resp_en = 1'b1; resp_lat = 1;
        start_download();
        for (int w = 1; w <= 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(25'(4 * (w - 1) + b), (b == 0) ? 8'(w) : 8'h00, ROM_IDX, 1);
            end
        end
        end_download(1);
        drain("checksum");
        check("checksum 1+2+3", checksum, 6);
`endif

        // Randomized sessions
        resp_en = 1'b1; resp_lat = 2;
        for (int s = 0; s < 5; s++) begin
            r0 = req_cnt; d0 = done_cnt;
            start_download();
            a = 25'($urandom);
            for (int i = 0; i < int'($urandom_range(20, 48)); i++) begin
                if ($urandom_range(0, 9) == 0) a = 25'($urandom);
                else a = a + 25'd1;
                idx = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1, 3)) : ROM_IDX;
                send_byte(a, 8'($urandom), idx, 1);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            end_download(1);
            drain("random");
            check("random done pulses", done_cnt - d0, m_any ? 1 : 0);
            check("random overrun", overrun, 0);
`ifdef DOWNLOAD_CHECKSUM_EN
            check("random checksum", checksum, m_sum);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/download_packer.md
DOWNLOAD_PACKER -- requirements
Module: download_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of packed 32-bit words buffered (power of two, >=2).
REQ-002 SHALL have parameter ROM_INDEX, default 16'h0000, meaning the ioctl_index value accepted for SDRAM writes.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have ports ioctl_addr input 25 (byte address), ioctl_data input 8 (byte), ioctl_index input 16, ioctl_wr input 1 (byte strobe), ioctl_download input 1 (download active).
REQ-006 SHALL have port ioctl_wait, output, 1, meaning the loader must stall byte strobes.
REQ-007 SHALL have ports sdram_addr output 23 (word address), sdram_data output 32, sdram_we output 1, sdram_req output 1, sdram_ack input 1, sdram_valid input 1.
REQ-008 SHALL have ports done output 1 (one-cycle completion pulse) and overrun output 1 (sticky byte-loss flag).

Function
REQ-009 SHALL accept a byte only when ioctl_download=1, ioctl_wr=1 and ioctl_index==ROM_INDEX; other strobes ignored.
REQ-010 SHALL place an accepted byte in lane ioctl_addr[1:0], bits [8*lane+7:8*lane] (little-endian), and set that lane's valid bit.
REQ-011 SHALL latch word address ioctl_addr[24:2] on every accepted byte.
REQ-012 SHALL push {word address, word} into the FIFO the cycle after a lane-3 byte is accepted, then clear lane data and valid bits.
REQ-013 SHALL push a pending word early when an accepted byte's ioctl_addr[24:2] differs from the latched word address (old word pushed first, new byte starts the next word).
REQ-014 SHALL, on the ioctl_download 1->0 edge, push any partial word with unwritten lanes zero.
REQ-015 SHALL run a write FSM: IDLE -> REQ when FIFO non-empty; REQ holds sdram_req=1, sdram_we=1 and stable sdram_addr/sdram_data (FIFO head) until sdram_ack=1; REQ -> WAIT on ack; WAIT -> IDLE and pops the head on sdram_valid=1.
REQ-016 SHALL drive sdram_req=0 and sdram_we=0 in IDLE and WAIT.
REQ-017 SHALL present the minimum request latency: a word pushed at cycle N drives sdram_req=1 at cycle N+1 when the FSM is IDLE.
REQ-018 SHALL assert ioctl_wait while FIFO occupancy >= FIFO_DEPTH-1.
REQ-019 SHALL, when a push is required while the FIFO is full, drop the word and set overrun=1 until reset.
REQ-020 SHALL treat simultaneous push and pop as count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL pulse done for exactly one cycle when ioctl_download=0, FIFO empty, no partial word, FSM IDLE, and a download has occurred since the last done.
REQ-022 SHALL ignore sdram_ack in IDLE/WAIT and sdram_valid in IDLE/REQ.

Reset
REQ-023 SHALL on reset clear FIFO, lane valid bits, word data, FSM to IDLE, and drive sdram_req=0, sdram_we=0, sdram_addr=0, sdram_data=0, ioctl_wait=0, done=0, overrun=0.
REQ-024 SHALL abandon any in-flight request on reset mid-transfer without issuing a further request.

Configuration
REQ-025 SHALL support macro DOWNLOAD_CHECKSUM_EN; when defined, adds output checksum (32 bits), the modulo-2^32 sum of every word acknowledged by sdram_valid, cleared by reset and on ioctl_download 0->1.
REQ-026 SHALL, without DOWNLOAD_CHECKSUM_EN, omit the checksum port and adder entirely; all other behaviour identical.

Verification
REQ-027 Bytes 11,22,33,44 at addr 0..3, ack/valid 1 cycle later -> one request addr 0, data 32'h44332211, we=1.
REQ-028 Bytes at addr 8,9 then download falls -> request addr 2, data 32'h00002211, then done pulses once.
REQ-029 Stream 64 bytes, sdram_ack held 0 -> ioctl_wait rises at occupancy 3 (DEPTH 4); loader stalls; overrun stays 0.
REQ-030 Same stream ignoring ioctl_wait -> fifth word dropped, overrun=1, exactly 4 requests.
REQ-031 Bytes with ioctl_index=1 -> no requests, done does not pulse.
REQ-032 Reset asserted in REQ state -> sdram_req=0 next cycle, FIFO empty, no later request; with DOWNLOAD_CHECKSUM_EN, words 1,2,3 written -> checksum=6.
